// File: rtl/compare_test_sequencer.sv
// Latency-matched self-check sequencer: drives an XOR-seeded ramp into a pipelined DUT
// and compares each returning word against a delayed copy of what was issued.
module compare_test_sequencer #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 3,
    parameter int CNT_W   = 16,
    parameter int ERR_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] stim_data,
    output logic             stim_valid,
    input  logic [WIDTH-1:0] dut_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        if (v == {ERR_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + ERR_ONE;
        end
    endfunction

    state_t           state_q;
    logic [CNT_W-1:0] num_q;
    logic [WIDTH-1:0] seed_q;
    logic [CNT_W-1:0] issue_idx_q;
    logic [CNT_W-1:0] compare_idx_q;
    logic             first_seen_q;
    logic [WIDTH-1:0] stim_data_q;
    logic             stim_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [ERR_W-1:0] err_count_q;
    logic [CNT_W-1:0] first_err_idx_q;

    logic [WIDTH-1:0] dly_data_q [LATENCY];
    logic [LATENCY-1:0] dly_vld_q;

    logic             tail_vld_s;
    logic             tail_miss_s;

    assign tail_vld_s  = dly_vld_q[LATENCY-1];
    assign tail_miss_s = tail_vld_s && (dut_data != dly_data_q[LATENCY-1]);

    // Expected-data delay line: the tail lines up with the DUT output for the same vector.
    always_ff @(posedge clk) begin
        if (!rst || abort) begin
            dly_vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dly_data_q[i] <= '0;
            end
        end else begin
            dly_vld_q[0]  <= stim_valid_q;
            dly_data_q[0] <= stim_data_q;
            for (int i = 1; i < LATENCY; i++) begin
                dly_vld_q[i]  <= dly_vld_q[i-1];
                dly_data_q[i] <= dly_data_q[i-1];
            end
        end
    end

    // Run sequencer with compare/error accounting and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst || abort) begin
            state_q         <= S_IDLE;
            num_q           <= '0;
            seed_q          <= '0;
            issue_idx_q     <= '0;
            compare_idx_q   <= '0;
            first_seen_q    <= 1'b0;
            stim_data_q     <= '0;
            stim_valid_q    <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            err_count_q     <= '0;
            first_err_idx_q <= '0;
        end else begin
            if (tail_vld_s) begin
                compare_idx_q <= compare_idx_q + CNT_ONE;
                if (tail_miss_s) begin
                    err_count_q <= sat_inc(err_count_q);
                    if (!first_seen_q) begin
                        first_seen_q    <= 1'b1;
                        first_err_idx_q <= compare_idx_q;
                    end
                end
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        num_q           <= num_vectors;
                        seed_q          <= seed;
                        compare_idx_q   <= '0;
                        first_seen_q    <= 1'b0;
                        err_count_q     <= '0;
                        first_err_idx_q <= '0;
                        if (num_vectors != '0) begin
                            // Vector 0 goes out in the cycle right after start.
                            state_q      <= S_RUN;
                            stim_valid_q <= 1'b1;
                            stim_data_q  <= seed;
                            issue_idx_q  <= CNT_ONE;
                            busy_q       <= 1'b1;
                            done_q       <= 1'b0;
                            pass_q       <= 1'b0;
                        end else begin
                            state_q      <= S_DONE;
                            stim_valid_q <= 1'b0;
                            issue_idx_q  <= '0;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            pass_q       <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (issue_idx_q == num_q) begin
                        state_q      <= S_DRAIN;
                        stim_valid_q <= 1'b0;
                    end else begin
                        stim_data_q <= issue_idx_q[WIDTH-1:0] ^ seed_q;
                        issue_idx_q <= issue_idx_q + CNT_ONE;
                    end
                end
                S_DRAIN: begin
                    if (compare_idx_q == num_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_count_q == '0);
                    end else begin
                        state_q <= S_DRAIN;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stim_data     = stim_data_q;
    assign stim_valid    = stim_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_compare_test_sequencer.sv
// Bench for compare_test_sequencer: a 3-stage register DUT with selectable corruption,
// checked against a run-level model of issued words, error count and first failing index.
module tb_compare_test_sequencer;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] num_vectors;
    logic [7:0]  seed;
    logic [7:0]  stim_data;
    logic        stim_valid;
    logic [7:0]  dut_data;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  err_count;
    logic [15:0] first_err_idx;

    int n_checks = 0;
    int n_fail   = 0;

    // 0 identity, 1 inverted, 2 force 0xFF on vectors 4 and 7, 3 corrupt per mask
    int          dut_mode = 0;
    bit          corrupt_mask [512];
    logic [7:0]  pd   [LAT];
    logic [15:0] pidx [LAT];
    logic [15:0] vec_cnt = 16'd0;
    logic [7:0]  stim_log [$];

    always #5 clk = ~clk;

    compare_test_sequencer #(.WIDTH(8), .LATENCY(LAT), .CNT_W(16), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_vectors(num_vectors), .seed(seed),
        .stim_data(stim_data), .stim_valid(stim_valid), .dut_data(dut_data),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_idx(first_err_idx)
    );

    // DUT stand-in pipeline and stimulus monitor
    always @(posedge clk) begin
        pd[0]   <= stim_data;
        pidx[0] <= vec_cnt;
        for (int i = 1; i < LAT; i++) begin
            pd[i]   <= pd[i-1];
            pidx[i] <= pidx[i-1];
        end
        if (start && !busy) begin
            vec_cnt <= 16'd0;
            stim_log.delete();
        end else if (stim_valid) begin
            vec_cnt <= vec_cnt + 16'd1;
            stim_log.push_back(stim_data);
        end
    end

    always_comb begin
        dut_data = pd[LAT-1];
        case (dut_mode)
            1: dut_data = ~pd[LAT-1];
            2: if (pidx[LAT-1] == 16'd4 || pidx[LAT-1] == 16'd7) dut_data = 8'hFF;
            3: if (corrupt_mask[pidx[LAT-1][8:0]]) dut_data = pd[LAT-1] ^ 8'h5A;
            default: dut_data = pd[LAT-1];
        endcase
    end

    // Reference: what a correct run of n vectors with seed s should report.
    function automatic void model_run(input int n, input logic [7:0] s,
                                      output int errs, output int first);
        logic [7:0] orig;
        logic [7:0] obs;
        errs  = 0;
        first = 0;
        for (int k = 0; k < n; k++) begin
            orig = 8'(k) ^ s;
            obs  = orig;
            if (dut_mode == 1) obs = ~orig;
            if (dut_mode == 2 && (k == 4 || k == 7)) obs = 8'hFF;
            if (dut_mode == 3 && corrupt_mask[k % 512]) obs = orig ^ 8'h5A;
            if (obs != orig) begin
                if (errs == 0) first = k;
                errs++;
            end
        end
        if (errs > 255) errs = 255;
    endfunction

    function automatic int stim_bad(input int n, input logic [7:0] s);
        int bad;
        bad = (stim_log.size() != n) ? 1 : 0;
        for (int k = 0; k < n && k < stim_log.size(); k++) begin
            if (stim_log[k] !== (8'(k) ^ s)) bad++;
        end
        return bad;
    endfunction

    // Pulse start for one edge, scramble the inputs afterwards, count edges until done.
    task automatic launch(input int n, input logic [7:0] s, output int edges);
        @(negedge clk);
        start = 1'b1;
        num_vectors = 16'(n);
        seed = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        num_vectors = 16'($urandom);
        seed = 8'($urandom);
        edges = 0;
        while (!done && edges < n + 60) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; abort = 1'b0; num_vectors = 16'd0; seed = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        n_checks++;
        if ({stim_valid, busy, done, pass} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, want 0000", {stim_valid, busy, done, pass});
        end
        n_checks++;
        if ({stim_data, err_count, first_err_idx} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, want 0", {stim_data, err_count, first_err_idx});
        end
    endtask

    task automatic test_identity();
        int e, xe, xf;
        dut_mode = 0;
        model_run(10, 8'h00, xe, xf);
        launch(10, 8'h00, e);
        n_checks++;
        if (e !== 14) begin n_fail++; $display("FAIL ident_done_edge: got %0d, want 14", e); end
        n_checks++;
        if (stim_bad(10, 8'h00) !== 0) begin
            n_fail++; $display("FAIL ident_stim: got %0d bad words, want 0", stim_bad(10, 8'h00));
        end
        n_checks++;
        if ({pass, busy} !== 2'b10) begin n_fail++; $display("FAIL ident_pass_busy: got %b, want 10", {pass, busy}); end
        n_checks++;
        if (err_count !== 8'(xe) || first_err_idx !== 16'(xf)) begin
            n_fail++; $display("FAIL ident_err: got %0d/%0d, want %0d/%0d", err_count, first_err_idx, xe, xf);
        end
    endtask

    task automatic test_errors();
        int e, xe, xf;
        dut_mode = 2;
        model_run(10, 8'h00, xe, xf);
        launch(10, 8'h00, e);
        n_checks++;
        if (e !== 14) begin n_fail++; $display("FAIL err_done_edge: got %0d, want 14", e); end
        n_checks++;
        if (err_count !== 8'(xe)) begin n_fail++; $display("FAIL err_count: got %0d, want %0d", err_count, xe); end
        n_checks++;
        if (first_err_idx !== 16'(xf)) begin n_fail++; $display("FAIL err_first: got %0d, want %0d", first_err_idx, xf); end
        n_checks++;
        if (pass !== 1'b0) begin n_fail++; $display("FAIL err_pass: got %b, want 0", pass); end
    endtask

    task automatic test_saturate();
        int e, xe, xf;
        dut_mode = 1;
        model_run(300, 8'hA5, xe, xf);
        launch(300, 8'hA5, e);
        n_checks++;
        if (e !== 304) begin n_fail++; $display("FAIL sat_done_edge: got %0d, want 304", e); end
        n_checks++;
        if (stim_bad(300, 8'hA5) !== 0) begin
            n_fail++; $display("FAIL sat_stim: got %0d bad words, want 0", stim_bad(300, 8'hA5));
        end
        n_checks++;
        if (stim_log.size() > 256 && stim_log[256] !== 8'hA5) begin
            n_fail++; $display("FAIL sat_wrap: got %h, want a5", stim_log[256]);
        end
        n_checks++;
        if (err_count !== 8'(xe) || first_err_idx !== 16'(xf) || pass !== 1'b0) begin
            n_fail++; $display("FAIL sat_err: got %0d/%0d/%b, want %0d/%0d/0", err_count, first_err_idx, pass, xe, xf);
        end
    endtask

    task automatic test_zero();
        int e;
        dut_mode = 1;
        launch(0, 8'h3C, e);
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (e !== 0) begin n_fail++; $display("FAIL zero_done_edge: got %0d, want 0", e); end
        n_checks++;
        if ({done, pass, busy} !== 3'b110 || err_count !== 8'd0) begin
            n_fail++; $display("FAIL zero_status: got %b/%0d, want 110/0", {done, pass, busy}, err_count);
        end
        n_checks++;
        if (stim_log.size() !== 0) begin n_fail++; $display("FAIL zero_stim: got %0d words, want 0", stim_log.size()); end
    endtask

    task automatic test_abort();
        int e;
        dut_mode = 1;
        @(negedge clk);
        start = 1'b1; num_vectors = 16'd20; seed = 8'h11;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = 0;
        while (stim_log.size() < 5 && e < 50) begin @(posedge clk); #1; e++; end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        n_checks++;
        if ({done, busy, stim_valid, pass} !== 4'b0000 || err_count !== 8'd0 || first_err_idx !== 16'd0) begin
            n_fail++;
            $display("FAIL abort_state: got %b/%0d/%0d, want 0000/0/0", {done, busy, stim_valid, pass}, err_count, first_err_idx);
        end
        dut_mode = 0;
        launch(3, 8'h5E, e);
        n_checks++;
        if (e !== 7) begin n_fail++; $display("FAIL abort_rerun_edge: got %0d, want 7", e); end
        n_checks++;
        if (pass !== 1'b1 || err_count !== 8'd0 || stim_bad(3, 8'h5E) !== 0) begin
            n_fail++; $display("FAIL abort_rerun: got pass %b err %0d, want 1/0", pass, err_count);
        end
    endtask

    task automatic test_reset_drain();
        int e;
        dut_mode = 1;
        @(negedge clk);
        start = 1'b1; num_vectors = 16'd5; seed = 8'h77;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = 0;
        while (!(busy && !stim_valid) && e < 50) begin @(posedge clk); #1; e++; end
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        n_checks++;
        if ({stim_valid, busy, done, pass} !== 4'b0000 || {stim_data, err_count, first_err_idx} !== 32'd0) begin
            n_fail++;
            $display("FAIL drain_reset: got %b/%h, want 0000/0", {stim_valid, busy, done, pass}, {stim_data, err_count, first_err_idx});
        end
        dut_mode = 0;
        launch(4, 8'h90, e);
        n_checks++;
        if (e !== 8 || pass !== 1'b1 || stim_bad(4, 8'h90) !== 0) begin
            n_fail++; $display("FAIL drain_rerun: got edge %0d pass %b, want 8/1", e, pass);
        end
    endtask

    task automatic test_random();
        int e, n, xe, xf;
        logic [7:0] s;
        dut_mode = 3;
        for (int it = 0; it < 8; it++) begin
            n = int'($urandom_range(1, 40));
            s = 8'($urandom);
            for (int k = 0; k < 512; k++) corrupt_mask[k] = (k < n) && ($urandom_range(0, 3) == 0);
            model_run(n, s, xe, xf);
            launch(n, s, e);
            n_checks++;
            if (e !== n + LAT + 1 || stim_bad(n, s) !== 0) begin
                n_fail++; $display("FAIL rand_timing[%0d]: got edge %0d, want %0d", it, e, n + LAT + 1);
            end
            n_checks++;
            if (err_count !== 8'(xe) || first_err_idx !== 16'(xf) || pass !== (xe == 0)) begin
                n_fail++;
                $display("FAIL rand_result[%0d]: got %0d/%0d/%b, want %0d/%0d/%b", it, err_count, first_err_idx, pass, xe, xf, xe == 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_errors();
        test_saturate();
        test_zero();
        test_abort();
        test_reset_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/compare_test_sequencer.md
Name: compare_test_sequencer

Overview:
- Sequences a latency-matched self-check run on a LATENCY-stage pass-through datapath under test (DUT).
- Issues N stimulus words to the DUT and delays a copy of each word internally by LATENCY cycles.
- Compares each delayed copy against the DUT output and counts mismatches.
- Reports done, pass/fail, the error count and the index of the first failing vector.
- Sits between the test-control registers and the DUT pipeline.

Parameters:
- WIDTH, 8, stimulus/DUT data width.
- LATENCY, 3, DUT pipeline depth in cycles (>=1).
- CNT_W, 16, width of vector count and index.
- ERR_W, 8, width of saturating error counter.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-low.
- start  input  1  begin run; sampled in IDLE or DONE.
- abort  input  1  cancel run; returns to IDLE.
- num_vectors  input  CNT_W  vectors to issue; latched on start.
- seed  input  WIDTH  stimulus XOR pattern; latched on start.
- stim_data  output  WIDTH  word driven to DUT.
- stim_valid  output  1  stim_data valid this cycle.
- dut_data  input  WIDTH  DUT output, expected LATENCY cycles after stim.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  high in DONE.
- pass  output  1  valid while done=1; high when err_count==0.
- err_count  output  ERR_W  mismatches seen, saturating.
- first_err_idx  output  CNT_W  vector index of first mismatch; 0 if none.

Behaviour:
- Reset (rst==0 at a posedge): state IDLE; all outputs 0; internal index counters, latched num_vectors/seed and expected delay line (data plus valid) cleared. Reset mid-run abandons the run with no done.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start=1, num_vectors!=0:
  - Go to RUN; latch num_vectors and seed.
  - Clear issue index, compare index, err_count, first_err_idx and the first-error flag; done=0.
- IDLE/DONE + start=1, num_vectors==0: go directly to DONE with pass=1 and err_count=0; no stim_valid.
- RUN:
  - stim_valid=1 every cycle; stim_data = issue_idx[WIDTH-1:0] ^ seed_q; issue_idx increments.
  - After the cycle issuing index num_vectors_q-1, go to DRAIN.
  - The first stim_valid appears the cycle after start is sampled.
- Delay line:
  - Each cycle the {stim_valid, stim_data} pair enters a LATENCY-deep register chain, cleared on reset and abort.
  - Its tail aligns with dut_data sampled LATENCY cycles after issue.
- Compare, on any cycle where the tail valid=1:
  - If dut_data != tail data: increment err_count, saturating at 2^ERR_W-1.
  - On the first mismatch of the run, capture compare_idx into first_err_idx.
  - compare_idx increments on every compare regardless of result.
- DRAIN: stim_valid=0; remain until the compare of the last vector is sampled, then go to DONE.
- DONE: done=1, busy=0; outputs hold until the next start or abort.
- Timing: start sampled at edge 0; vector k issued in cycle k+1 and compared at edge k+1+LATENCY; done rises the cycle after the final compare, i.e. N+LATENCY+1 edges after start.
- Priority: rst > abort > start.
  - abort in any state: go to IDLE, clear the delay line, done=0, busy=0; err_count and first_err_idx are cleared.
  - start during RUN/DRAIN is ignored.
  - Changes to num_vectors or seed after start have no effect.
- Widths: compare_idx and issue_idx are CNT_W wide; num_vectors up to 2^CNT_W-1 is supported with no wrap.
- err_count never wraps.

Test Plan:
- Identity DUT (3-stage register), seed=0x00, N=10, start pulse → stim_data 0x00..0x09; done at edge 14; pass=1, err_count=0, first_err_idx=0.
- Same setup, DUT forces dut_data=0xFF on the compare of vector 4 and vector 7 → err_count=2, first_err_idx=4, pass=0.
- seed=0xA5, N=300, DUT output inverted → stim_data wraps after 0xFF (index 256 gives 0xA5); err_count saturates at 255; first_err_idx=0.
- num_vectors=0 with start → DONE the next cycle, pass=1, stim_valid never asserted.
- abort at vector 5 of N=20, then start N=3 → no done for the aborted run; the delay line is empty; second run passes with err_count=0 and done after 7 edges.
- rst=0 held one cycle mid-DRAIN → all outputs 0 and IDLE next cycle; a later start runs normally.
